// File: rtl/l1_biu_pkg.sv
// l1_biu_pkg: shared types and constants for the L1 bus interface unit.
// States, one-hot access sizes and line/beat geometry helpers.
package l1_biu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LINE_RD,
    ST_SGL_RD,
    ST_SGL_WR,
    ST_RESP,
    ST_ERR
  } state_t;

  localparam logic [3:0] SZ_1B = 4'b0001;
  localparam logic [3:0] SZ_2B = 4'b0010;
  localparam logic [3:0] SZ_4B = 4'b0100;
  localparam logic [3:0] SZ_8B = 4'b1000;

  localparam int BUS_BEAT_BYTES = 8;
  localparam int DEF_LINE_BYTES = 1024;

  function automatic int beat_cnt(int lb);
    return lb / BUS_BEAT_BYTES;
  endfunction

  function automatic int idx_w(int lb);
    return $clog2(lb / BUS_BEAT_BYTES);
  endfunction

  localparam int BEAT_CNT   = beat_cnt(DEF_LINE_BYTES);
  localparam int BEAT_IDX_W = idx_w(DEF_LINE_BYTES);

endpackage

// File: rtl/l1_biu_if.sv
// l1_biu_if: single-beat system bus between the BIU and a bus slave.
// The BIU drives the request side; the slave answers with ack/err.
interface l1_biu_if;

  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [3:0]  bus_size;
  logic [63:0] bus_wdata;
  logic [63:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr,
    output bus_size, bus_wdata,
    input  bus_rdata, bus_ack, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr,
    input  bus_size, bus_wdata,
    output bus_rdata, bus_ack, bus_err
  );

endinterface

// File: rtl/biu_watchdog.sv
// biu_watchdog: counts unanswered bus cycles and flags a hung beat.
// expire is high in the cycle the count reaches TIMEOUT with no answer.
module biu_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt <= '0;
    end else if (cnt != TMO) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expire = en && !clr && (cnt == TMO);

endmodule

// File: rtl/l1_biu_ctrl.sv
// l1_biu_ctrl: L1 miss / uncached access controller.
// Runs line fills, single reads and write-throughs on the bus.
module l1_biu_ctrl
  import l1_biu_pkg::*;
#(
  parameter int LINE_BYTES = 1024,
  parameter int BEAT_BYTES = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_line_req,
  input  logic        read_req,
  input  logic        write_through_req,
  input  logic [3:0]  L1_size,
  input  logic [63:0] pa,
  input  logic [63:0] wt_data,
  output logic [63:0] line_data,
  output logic [10:0] addr_count,
  output logic        line_write,
  output logic        cache_entry_refill,
  output logic        trans_rdy,
  output logic        bus_error,
  l1_biu_if.master    bus
);

  localparam int OFF     = $clog2(LINE_BYTES);
  localparam int BEAT_SH = $clog2(BEAT_BYTES);
  localparam int IDX_W   = idx_w(LINE_BYTES);
  localparam int BCNT    = beat_cnt(LINE_BYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BCNT - 1);

  state_t           state;
  logic [IDX_W-1:0] beat;
  logic [IDX_W-1:0] beat_nxt;
  logic             wd_expire;
  logic             fail;

  biu_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.bus_req),
    .clr    (bus.bus_ack | bus.bus_err),
    .expire (wd_expire)
  );

  // Error wins over a same-cycle ack.
  assign fail     = bus.bus_err | wd_expire;
  assign beat_nxt = beat + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      beat               <= '0;
      line_data          <= '0;
      addr_count         <= '0;
      line_write         <= 1'b0;
      cache_entry_refill <= 1'b0;
      trans_rdy          <= 1'b0;
      bus_error          <= 1'b0;
      bus.bus_req        <= 1'b0;
      bus.bus_we         <= 1'b0;
      bus.bus_addr       <= '0;
      bus.bus_size       <= '0;
      bus.bus_wdata      <= '0;
    end else begin
      line_write         <= 1'b0;
      cache_entry_refill <= 1'b0;
      trans_rdy          <= 1'b0;
      bus_error          <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          priority case (1'b1)
            read_line_req: begin
              state        <= ST_LINE_RD;
              beat         <= '0;
              bus.bus_req  <= 1'b1;
              bus.bus_we   <= 1'b0;
              bus.bus_size <= SZ_8B;
              bus.bus_addr <= {pa[63:OFF], {OFF{1'b0}}};
            end
            read_req: begin
              state        <= ST_SGL_RD;
              bus.bus_req  <= 1'b1;
              bus.bus_we   <= 1'b0;
              bus.bus_size <= L1_size;
              bus.bus_addr <= pa;
            end
            write_through_req: begin
              state         <= ST_SGL_WR;
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= 1'b1;
              bus.bus_size  <= L1_size;
              bus.bus_addr  <= pa;
              bus.bus_wdata <= wt_data;
            end
            default: ;
          endcase
        end
        ST_LINE_RD: begin
          if (fail) begin
            state       <= ST_ERR;
            bus.bus_req <= 1'b0;
            bus_error   <= 1'b1;
          end else if (bus.bus_ack) begin
            line_data  <= bus.bus_rdata;
            addr_count <= 11'({beat, {BEAT_SH{1'b0}}});
            line_write <= 1'b1;
            if (beat == LAST) begin
              state              <= ST_RESP;
              bus.bus_req        <= 1'b0;
              trans_rdy          <= 1'b1;
              cache_entry_refill <= 1'b1;
            end else begin
              beat         <= beat_nxt;
              bus.bus_addr <= {bus.bus_addr[63:OFF],
                               beat_nxt,
                               {BEAT_SH{1'b0}}};
            end
          end
        end
        ST_SGL_RD: begin
          if (fail) begin
            state       <= ST_ERR;
            bus.bus_req <= 1'b0;
            bus_error   <= 1'b1;
          end else if (bus.bus_ack) begin
            state       <= ST_RESP;
            bus.bus_req <= 1'b0;
            line_data   <= bus.bus_rdata;
            trans_rdy   <= 1'b1;
          end
        end
        ST_SGL_WR: begin
          if (fail) begin
            state       <= ST_ERR;
            bus.bus_req <= 1'b0;
            bus_error   <= 1'b1;
          end else if (bus.bus_ack) begin
            state       <= ST_RESP;
            bus.bus_req <= 1'b0;
            trans_rdy   <= 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_biu_ctrl.sv
// tb_l1_biu_ctrl: directed bench for the L1 BIU controller.
// LINE_BYTES=64, TIMEOUT=10; outputs sampled 1 time unit after posedge.
module tb_l1_biu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_line_req;
  logic        read_req;
  logic        write_through_req;
  logic [3:0]  L1_size;
  logic [63:0] pa;
  logic [63:0] wt_data;
  logic [63:0] line_data;
  logic [10:0] addr_count;
  logic        line_write;
  logic        cache_entry_refill;
  logic        trans_rdy;
  logic        bus_error;

  int n_chk  = 0;
  int n_pass = 0;
  int lw_cnt = 0;

  l1_biu_if bif ();

  l1_biu_ctrl #(
    .LINE_BYTES (64),
    .BEAT_BYTES (8),
    .TIMEOUT    (10)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .read_line_req      (read_line_req),
    .read_req           (read_req),
    .write_through_req  (write_through_req),
    .L1_size            (L1_size),
    .pa                 (pa),
    .wt_data            (wt_data),
    .line_data          (line_data),
    .addr_count         (addr_count),
    .line_write         (line_write),
    .cache_entry_refill (cache_entry_refill),
    .trans_rdy          (trans_rdy),
    .bus_error          (bus_error),
    .bus                (bif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (line_write === 1'b1) lw_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic chk_pulses(input string tag,
                            input logic [3:0] exp);
    chk(tag,
        64'({line_write, cache_entry_refill, trans_rdy, bus_error}),
        64'(exp));
  endtask

  initial begin
    rst = 1'b1;
    read_line_req = 0;
    read_req = 0;
    write_through_req = 0;
    L1_size = 4'b0000;
    pa = '0;
    wt_data = '0;
    bif.bus_rdata = '0;
    bif.bus_ack = 0;
    bif.bus_err = 0;
    step();
    step();
    chk("rst_bus_req", 64'(bif.bus_req), 64'd0);
    chk("rst_bus_we", 64'(bif.bus_we), 64'd0);
    chk("rst_bus_addr", bif.bus_addr, 64'd0);
    chk("rst_bus_size", 64'(bif.bus_size), 64'd0);
    chk("rst_bus_wdata", bif.bus_wdata, 64'd0);
    chk("rst_line_data", line_data, 64'd0);
    chk("rst_addr_count", 64'(addr_count), 64'd0);
    chk_pulses("rst_pulses", 4'b0000);
    rst = 1'b0;

    // single read, ack at cycle 4
    read_req = 1;
    pa = 64'h8000_0010;
    L1_size = 4'b0100;
    step();
    read_req = 0;
    pa = 64'hFFFF_0000;
    chk("rd_req_c1", 64'(bif.bus_req), 64'd1);
    chk("rd_addr", bif.bus_addr, 64'h8000_0010);
    chk("rd_size", 64'(bif.bus_size), 64'h4);
    chk("rd_we", 64'(bif.bus_we), 64'd0);
    step();
    step();
    chk("rd_req_c3", 64'(bif.bus_req), 64'd1);
    step();
    bif.bus_ack = 1;
    bif.bus_rdata = 64'hDEAD_BEEF;
    step();
    bif.bus_ack = 0;
    chk_pulses("rd_c5_pulses", 4'b0010);
    chk("rd_line_data", line_data, 64'hDEAD_BEEF);
    chk("rd_req_c5", 64'(bif.bus_req), 64'd0);
    step();
    chk_pulses("rd_c6_pulses", 4'b0000);

    // write-through, zero-wait
    write_through_req = 1;
    pa = 64'h1000;
    wt_data = 64'h1122_3344_5566_7788;
    L1_size = 4'b1000;
    step();
    write_through_req = 0;
    chk("wr_req", 64'(bif.bus_req), 64'd1);
    chk("wr_we", 64'(bif.bus_we), 64'd1);
    chk("wr_addr", bif.bus_addr, 64'h1000);
    chk("wr_wdata", bif.bus_wdata, 64'h1122_3344_5566_7788);
    bif.bus_ack = 1;
    step();
    bif.bus_ack = 0;
    chk_pulses("wr_c2_pulses", 4'b0010);
    chk("wr_line_data_held", line_data, 64'hDEAD_BEEF);
    step();
    chk_pulses("wr_c3_pulses", 4'b0000);

    // line fill; read_req raised together, fill must win
    lw_cnt = 0;
    read_line_req = 1;
    read_req = 1;
    pa = 64'h2038;
    L1_size = 4'b0001;
    step();
    read_line_req = 0;
    read_req = 0;
    chk("fill_size", 64'(bif.bus_size), 64'h8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fill_addr%0d", i), bif.bus_addr,
          64'h2000 + 64'(i * 8));
      chk($sformatf("fill_req%0d", i), 64'(bif.bus_req), 64'd1);
      bif.bus_ack = 1;
      bif.bus_rdata = 64'(i);
      step();
      chk($sformatf("fill_lw%0d", i), 64'(line_write), 64'd1);
      chk($sformatf("fill_ac%0d", i), 64'(addr_count),
          64'(i * 8));
      chk($sformatf("fill_ld%0d", i), line_data, 64'(i));
      chk($sformatf("fill_done%0d", i),
          64'({cache_entry_refill, trans_rdy}),
          (i == 7) ? 64'd3 : 64'd0);
    end
    bif.bus_ack = 0;
    step();
    chk_pulses("fill_after", 4'b0000);
    chk("fill_req_after", 64'(bif.bus_req), 64'd0);
    chk("fill_lw_cnt", 64'(lw_cnt), 64'd8);

    // line fill, err together with ack on beat 3
    lw_cnt = 0;
    read_line_req = 1;
    pa = 64'h4010;
    step();
    read_line_req = 0;
    for (int i = 0; i < 3; i++) begin
      bif.bus_ack = 1;
      bif.bus_rdata = 64'(100 + i);
      step();
    end
    chk("err_addr3", bif.bus_addr, 64'h4018);
    bif.bus_err = 1;
    step();
    bif.bus_ack = 0;
    bif.bus_err = 0;
    chk_pulses("err_pulses", 4'b0001);
    chk("err_req_low", 64'(bif.bus_req), 64'd0);
    chk("err_ld_kept", line_data, 64'd102);
    step();
    chk_pulses("err_after", 4'b0000);
    chk("err_lw_cnt", 64'(lw_cnt), 64'd3);

    // watchdog, no answer
    read_req = 1;
    pa = 64'h3000;
    L1_size = 4'b0001;
    step();
    read_req = 0;
    chk("wd_req_rose", 64'(bif.bus_req), 64'd1);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("wd_wait%0d", k),
          64'({bif.bus_req, bus_error}), 64'b10);
    end
    step();
    chk("wd_bus_error", 64'(bus_error), 64'd1);
    chk("wd_req_low", 64'(bif.bus_req), 64'd0);
    step();
    chk("wd_err_end", 64'(bus_error), 64'd0);

    // normal access after the timeout
    write_through_req = 1;
    pa = 64'h5000;
    wt_data = 64'hA5A5;
    L1_size = 4'b0010;
    step();
    write_through_req = 0;
    chk("post_wd_addr", bif.bus_addr, 64'h5000);
    chk("post_wd_size", 64'(bif.bus_size), 64'h2);
    bif.bus_ack = 1;
    step();
    bif.bus_ack = 0;
    chk_pulses("post_wd_done", 4'b0010);
    step();

    // reset during a fill at beat 2
    read_line_req = 1;
    pa = 64'h6000;
    step();
    read_line_req = 0;
    bif.bus_ack = 1;
    bif.bus_rdata = 64'h77;
    step();
    step();
    chk("mid_addr2", bif.bus_addr, 64'h6010);
    bif.bus_ack = 0;
    rst = 1;
    step();
    rst = 0;
    chk("mr_req", 64'(bif.bus_req), 64'd0);
    chk("mr_addr", bif.bus_addr, 64'd0);
    chk("mr_size", 64'(bif.bus_size), 64'd0);
    chk("mr_line_data", line_data, 64'd0);
    chk("mr_addr_count", 64'(addr_count), 64'd0);
    chk_pulses("mr_pulses", 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
